mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter placed between the cache refill/uncached engines and the single external memory port of the CPU. It shares the port between the instruction side (read bursts only) and the data side (read or write bursts). Arbitration uses fixed data-over-instruction priority with a starvation limit for instruction fetch. Each granted transaction holds the port until it completes.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, beat width
- LEN_WIDTH, 4, burst length field; the field holds beats−1
- STARVE_LIMIT, 4, consecutive data grants while inst waits before inst is forced to win
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- i_req_valid / i_req_ready  in/out  1  inst request handshake
- i_req_addr  in  ADDR_WIDTH  inst burst start address
- i_req_len  in  LEN_WIDTH  inst beats−1
- i_rvalid, i_rlast  out  1  inst read beat valid / last beat
- i_rdata  out  DATA_WIDTH  inst read beat
- d_req_valid / d_req_ready  in/out  1  data request handshake
- d_req_addr  in  ADDR_WIDTH  data start address
- d_req_len  in  LEN_WIDTH  data beats−1
- d_req_write  in  1  1 = write burst
- d_rvalid, d_rlast  out  1  data read beat valid / last beat
- d_rdata  out  DATA_WIDTH  data read beat
- d_wvalid, d_wlast  in  1  data write beat valid / last beat
- d_wready  out  1  data write beat accepted
- d_wdata  in  DATA_WIDTH  data write beat
- d_bvalid  out  1  one-cycle write-complete pulse
- mem_req_valid / mem_req_ready  out/in  1  memory address handshake
- mem_req_addr, mem_req_len, mem_req_write  out  ADDR/LEN/1  forwarded from the owner
- mem_rvalid, mem_rlast  in  1  memory read beat valid / last beat
- mem_rdata  in  DATA_WIDTH  memory read beat
- mem_wvalid, mem_wlast  out  1  memory write beat valid / last beat
- mem_wdata  out  DATA_WIDTH  memory write beat
- mem_wready  in  1  memory write beat accepted
- mem_bvalid  in  1  memory write response

## Operation
- FSM states: IDLE, ADDR, RDATA, WDATA, WRESP. Owner register: 0 = inst, 1 = data.
- IDLE transitions:
  - Both requests low: stay in IDLE.
  - Otherwise register the winner as owner and go to ADDR.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
- starve_cnt:
  - Increments on a data grant while i_req_valid = 1, saturating at STARVE_LIMIT.
  - Clears on any inst grant, and in any IDLE cycle with i_req_valid = 0.
- ADDR state:
  - mem_req_valid = 1; addr/len/write are taken from the owner (write is 0 when inst owns).
  - Owner's req_ready = mem_req_ready. The non-owner's req_ready stays 0.
  - On the handshake, go to WDATA if the transfer is a write, otherwise RDATA.
- RDATA state:
  - mem_rvalid/rdata/rlast pass combinationally to the owner's r* outputs.
  - Non-owner r* outputs stay 0.
  - A beat with mem_rvalid && mem_rlast returns the FSM to IDLE.
- WDATA state:
  - mem_wvalid = d_wvalid, mem_wdata = d_wdata, mem_wlast = d_wlast, d_wready = mem_wready.
  - A beat with mem_wvalid && mem_wready && mem_wlast moves the FSM to WRESP.
- WRESP state: d_bvalid = mem_bvalid; on mem_bvalid, return to IDLE.
- Outside its state, each memory output and each pass-through output is 0.
  - mem_rvalid in IDLE or WDATA is ignored and not forwarded.
  - d_wvalid outside WDATA is not accepted.
- Requesters must hold addr/len/write stable from req_valid until req_ready and must not withdraw req_valid. Beat counts are not checked; rlast and wlast alone end the phases.
- Reset state: IDLE, owner = 0, starve_cnt = 0. All outputs are 0 during and after reset.
- Reset mid-burst: abandon the transfer. The external memory is reset by the same rst.

## Timing
- A request first seen in IDLE at cycle t gives mem_req_valid = 1 at t+1. No combinational path runs from req_valid to mem_req_valid.
- If mem_req_ready = 1 at t+1, the owner's req_ready pulses at t+1.
- Read beats reach the requester in the same cycle (zero latency).
- When the last beat or bvalid arrives at cycle t, the FSM is in IDLE at t+1. The next mem_req_valid can assert no earlier than t+2, giving a 1-cycle bubble between transactions.
- Single-beat burst (len = 0): rlast and wlast are asserted on the first beat.

## Structure
- The cpu_defs package holds:
  - mem_arb_state_t (enum of the five FSM states)
  - MEM_ARB_INST = 0 and MEM_ARB_DATA = 1
  - mem_req_t (addr, len, write)
- One sub-module, mem_arb_pick, contains the winner selection and the starve_cnt register, with outputs grant_valid and grant_id. The top level holds the FSM and all muxing.

## Test plan
- Inst read only: len = 3, addr 0x1fc0_0000, 4 beats 0xA0..0xA3 → mem_req_valid one cycle after request; beats forwarded on i_r* with i_rlast on the 4th; d_r* stays 0.
- Simultaneous request, STARVE_LIMIT = 4: data wins; after 4 back-to-back data grants with inst pending, inst wins the 5th; starve_cnt then reads 0.
- Data write: len = 1, mem_wready low for 2 cycles, data 0x1234/0x5678 → mem_w* mirrors d_w*; d_wready only when mem_wready = 1; d_bvalid pulses exactly once.
- Spurious mem_rvalid in IDLE, and during WDATA → no r* output toggles; FSM state unchanged.
- rst asserted on the 2nd beat of a read burst → next cycle the FSM is in IDLE with all outputs 0; a fresh inst request is then granted normally.
- mem_req_ready held low for 5 cycles → mem_req_valid and address held stable for all 5 cycles; req_ready stays 0 until the handshake.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared types for the CPU memory subsystem: arbiter FSM states, requester ids
// and the request payload forwarded to the external memory port.
package cpu_defs;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RDATA,
    WDATA,
    WRESP
  } mem_arb_state_t;

  localparam logic MEM_ARB_INST = 1'b0;
  localparam logic MEM_ARB_DATA = 1'b1;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LEN_W-1:0]  len;
    logic                  write;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter: data has priority over inst unless
// inst has been passed over STARVE_LIMIT consecutive times.
module mem_arb_pick
  import cpu_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic i_req_valid_i,
  input  logic d_req_valid_i,
  output logic grant_valid,
  output logic grant_id
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  always_comb begin
    starved     = (starve_q == CNT_W'(STARVE_LIMIT));
    grant_valid = idle_i && (i_req_valid_i || d_req_valid_i);
    grant_id    = MEM_ARB_INST;
    starve_d    = starve_q;
    if (d_req_valid_i && !(i_req_valid_i && starved)) begin
      grant_id = MEM_ARB_DATA;
    end
    // Count only data grants that bypass a waiting inst request.
    if (idle_i) begin
      if (!i_req_valid_i || (grant_valid && grant_id == MEM_ARB_INST)) begin
        starve_d = '0;
      end else if (grant_valid && !starved) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the external memory port between instruction
// fetch (reads) and data (reads/writes); each grant owns the port to completion.
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_WIDTH   = MEM_ADDR_W,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = MEM_LEN_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LEN_WIDTH-1:0]  i_req_len,
  output logic                  i_rvalid,
  output logic                  i_rlast,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LEN_WIDTH-1:0]  d_req_len,
  input  logic                  d_req_write,
  output logic                  d_rvalid,
  output logic                  d_rlast,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_wvalid,
  input  logic                  d_wlast,
  output logic                  d_wready,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_bvalid,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LEN_WIDTH-1:0]  mem_req_len,
  output logic                  mem_req_write,
  input  logic                  mem_rvalid,
  input  logic                  mem_rlast,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  output logic                  mem_wlast,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic                  mem_bvalid
);

  mem_arb_state_t state_q, state_d;
  logic           owner_q, owner_d;
  logic           grant_valid, grant_id;
  mem_req_t       req;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .idle_i       ((state_q == IDLE) && !rst),
    .i_req_valid_i(i_req_valid),
    .d_req_valid_i(d_req_valid),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  // Request fields of the current owner; inst never writes.
  always_comb begin
    if (owner_q == MEM_ARB_DATA) begin
      req = '{addr: MEM_ADDR_W'(d_req_addr), len: MEM_LEN_W'(d_req_len), write: d_req_write};
    end else begin
      req = '{addr: MEM_ADDR_W'(i_req_addr), len: MEM_LEN_W'(i_req_len), write: 1'b0};
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    i_req_ready   = 1'b0;
    i_rvalid      = 1'b0;
    i_rlast       = 1'b0;
    i_rdata       = '0;
    d_req_ready   = 1'b0;
    d_rvalid      = 1'b0;
    d_rlast       = 1'b0;
    d_rdata       = '0;
    d_wready      = 1'b0;
    d_bvalid      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_len   = '0;
    mem_req_write = 1'b0;
    mem_wvalid    = 1'b0;
    mem_wlast     = 1'b0;
    mem_wdata     = '0;
    // Everything reads as zero while reset is held, whatever the state.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_d = grant_id;
            state_d = ADDR;
          end
        end
        ADDR: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = ADDR_WIDTH'(req.addr);
          mem_req_len   = LEN_WIDTH'(req.len);
          mem_req_write = req.write;
          d_req_ready   = (owner_q == MEM_ARB_DATA) && mem_req_ready;
          i_req_ready   = (owner_q == MEM_ARB_INST) && mem_req_ready;
          if (mem_req_ready) begin
            state_d = req.write ? WDATA : RDATA;
          end
        end
        RDATA: begin
          if (owner_q == MEM_ARB_DATA) begin
            d_rvalid = mem_rvalid;
            d_rdata  = mem_rdata;
            d_rlast  = mem_rlast;
          end else begin
            i_rvalid = mem_rvalid;
            i_rdata  = mem_rdata;
            i_rlast  = mem_rlast;
          end
          if (mem_rvalid && mem_rlast) begin
            state_d = IDLE;
          end
        end
        WDATA: begin
          mem_wvalid = d_wvalid;
          mem_wdata  = d_wdata;
          mem_wlast  = d_wlast;
          d_wready   = mem_wready;
          if (d_wvalid && mem_wready && d_wlast) begin
            state_d = WRESP;
          end
        end
        WRESP: begin
          d_bvalid = mem_bvalid;
          if (mem_bvalid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= MEM_ARB_INST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scripted scenarios plus randomized
// traffic, with grant order predicted from the priority/starvation rules.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned SL = 4;

  logic          clk;
  logic          rst;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_len;
  logic          i_rvalid, i_rlast;
  logic [DW-1:0] i_rdata;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_len;
  logic          d_req_write;
  logic          d_rvalid, d_rlast;
  logic [DW-1:0] d_rdata;
  logic          d_wvalid, d_wlast, d_wready;
  logic [DW-1:0] d_wdata;
  logic          d_bvalid;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_len;
  logic          mem_req_write;
  logic          mem_rvalid, mem_rlast;
  logic [DW-1:0] mem_rdata;
  logic          mem_wvalid, mem_wlast;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready, mem_bvalid;

  int            tests_run = 0;
  int            fails = 0;
  int            streak = 0;
  logic [DW-1:0] rdat [16];
  logic [DW-1:0] wdat [16];

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_len(d_req_len), .d_req_write(d_req_write), .d_rvalid(d_rvalid),
    .d_rlast(d_rlast), .d_rdata(d_rdata), .d_wvalid(d_wvalid), .d_wlast(d_wlast),
    .d_wready(d_wready), .d_wdata(d_wdata), .d_bvalid(d_bvalid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len), .mem_req_write(mem_req_write),
    .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wlast(mem_wlast), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_bvalid(mem_bvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [143:0] outs();
    return {i_req_ready, i_rvalid, i_rlast, i_rdata, d_req_ready, d_rvalid, d_rlast,
            d_rdata, d_wready, d_bvalid, mem_req_valid, mem_req_addr, mem_req_len,
            mem_req_write, mem_wvalid, mem_wlast, mem_wdata};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = 0; i_req_addr = '0; i_req_len = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_len = '0; d_req_write = 0;
    d_wvalid = 0; d_wlast = 0; d_wdata = '0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rlast = 0; mem_rdata = '0;
    mem_wready = 0; mem_bvalid = 0;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) begin
      rdat[k] = $urandom;
      wdat[k] = $urandom;
    end
  endtask

  // Reference arbitration: data first, inst forced after SL bypasses in a row.
  task automatic model_grant(input logic ip, input logic dp, output logic who);
    if (ip && !dp) who = 1'b0;
    else if (!ip) who = 1'b1;
    else who = (streak == int'(SL)) ? 1'b0 : 1'b1;
    if (!who || !ip) streak = 0;
    else if (streak < int'(SL)) streak++;
  endtask

  // Acts as the memory for one transaction owned by exp_own (0 inst, 1 data).
  task automatic serve_txn(input logic exp_own, input int stall_a, input int stall_w,
                           input bit gaps, input bit spur);
    logic          wr, v;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
    logic [33:0]   bv;
    logic [67:0]   exp_r;
    int            c, beat;
    wr   = exp_own & d_req_write;
    len  = exp_own ? d_req_len : i_req_len;
    addr = exp_own ? d_req_addr : i_req_addr;
    c = 0;
    #1;
    while (mem_req_valid !== 1'b1 && c < 8) begin
      nxt(); #1; c++;
    end
    tests_run++;
    if (mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL grant_timeout: mem_req_valid=%b required 1", mem_req_valid);
      return;
    end
    c = 0;
    forever begin
      mem_req_ready = (stall_a >= 0) ? (c >= stall_a) : ($urandom_range(0, 2) == 0);
      #1;
      tests_run++;
      if ({mem_req_valid, mem_req_addr, mem_req_len, mem_req_write} !== {1'b1, addr, len, wr}) begin
        fails++;
        $display("FAIL addr_phase: got v=%b a=%h l=%h w=%b required 1 %h %h %b",
                 mem_req_valid, mem_req_addr, mem_req_len, mem_req_write, addr, len, wr);
      end
      tests_run++;
      if ({i_req_ready, d_req_ready} !== (mem_req_ready ? (exp_own ? 2'b01 : 2'b10) : 2'b00)) begin
        fails++;
        $display("FAIL req_ready: got i=%b d=%b mem_req_ready=%b owner=%b",
                 i_req_ready, d_req_ready, mem_req_ready, exp_own);
      end
      nxt();
      if (mem_req_ready || c > 40) break;
      c++;
    end
    mem_req_ready = 0;
    if (!wr) begin
      beat = 0; c = 0;
      while (beat <= int'(len) && c < 200) begin
        v = !gaps || ($urandom_range(0, 3) != 0);
        mem_rvalid = v;
        mem_rdata  = v ? rdat[beat] : $urandom;
        mem_rlast  = v && (beat == int'(len));
        #1;
        bv    = {v, mem_rdata, mem_rlast};
        exp_r = exp_own ? {34'b0, bv} : {bv, 34'b0};
        tests_run++;
        if ({i_rvalid, i_rdata, i_rlast, d_rvalid, d_rdata, d_rlast} !== exp_r) begin
          fails++;
          $display("FAIL rbeat%0d: got i=%b/%h/%b d=%b/%h/%b required %h", beat,
                   i_rvalid, i_rdata, i_rlast, d_rvalid, d_rdata, d_rlast, exp_r);
        end
        if (v) beat++;
        nxt(); c++;
      end
      mem_rvalid = 0; mem_rlast = 0;
      #1;
      tests_run++;
      if (mem_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL bubble_read: mem_req_valid=%b required 0", mem_req_valid);
      end
    end else begin
      beat = 0; c = 0;
      while (beat <= int'(len) && c < 200) begin
        d_wvalid   = !gaps || ($urandom_range(0, 3) != 0);
        d_wdata    = wdat[beat];
        d_wlast    = (beat == int'(len));
        mem_wready = (stall_w >= 0) ? (c >= stall_w) : ($urandom_range(0, 1) == 1);
        mem_rvalid = spur; mem_rlast = spur; mem_rdata = $urandom;
        #1;
        tests_run++;
        if ({mem_wvalid, mem_wdata, mem_wlast, d_wready} !== {d_wvalid, wdat[beat], d_wlast, mem_wready}) begin
          fails++;
          $display("FAIL wbeat%0d: got %b/%h/%b ready=%b required %b/%h/%b ready=%b", beat,
                   mem_wvalid, mem_wdata, mem_wlast, d_wready, d_wvalid, wdat[beat], d_wlast, mem_wready);
        end
        tests_run++;
        if ({i_rvalid, i_rdata, i_rlast, d_rvalid, d_rdata, d_rlast} !== 68'b0) begin
          fails++;
          $display("FAIL r_leak_wdata: got i=%b d=%b required 0", i_rvalid, d_rvalid);
        end
        if (d_wvalid && mem_wready) beat++;
        nxt(); c++;
      end
      // Stray write beats during the response wait must not reach memory.
      d_wvalid = 1; d_wlast = 1; mem_wready = 1;
      mem_rvalid = 0; mem_rlast = 0;
      c = gaps ? int'($urandom_range(0, 3)) : 1;
      repeat (c) begin
        #1;
        tests_run++;
        if ({d_bvalid, mem_wvalid, d_wready} !== 3'b000) begin
          fails++;
          $display("FAIL wresp_wait: got b=%b wv=%b wr=%b required 000", d_bvalid, mem_wvalid, d_wready);
        end
        nxt();
      end
      mem_bvalid = 1;
      #1;
      tests_run++;
      if (d_bvalid !== 1'b1) begin
        fails++;
        $display("FAIL bvalid: got %b required 1", d_bvalid);
      end
      nxt();
      d_wvalid = 0; d_wlast = 0; mem_wready = 0;
      #1;
      tests_run++;
      if ({d_bvalid, mem_req_valid} !== 2'b00) begin
        fails++;
        $display("FAIL bvalid_once: got b=%b req_v=%b required 00", d_bvalid, mem_req_valid);
      end
      mem_bvalid = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    i_req_valid = 1; d_req_valid = 1; mem_req_ready = 1; mem_rvalid = 1; mem_rlast = 1;
    mem_rdata = $urandom; d_wvalid = 1; mem_wready = 1; mem_bvalid = 1; d_wdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (outs() !== 144'b0) begin
        fails++;
        $display("FAIL reset_hold%0d: outputs=%h required 0", k, outs());
      end
      nxt();
    end
    clear_inputs();
    rst = 0;
    streak = 0;
    #1;
    tests_run++;
    if (outs() !== 144'b0) begin
      fails++;
      $display("FAIL reset_after: outputs=%h required 0", outs());
    end
    nxt();
  endtask

  task automatic test_inst_read();
    logic who;
    i_req_addr = 32'h1fc0_0000; i_req_len = 4'd3;
    for (int k = 0; k < 4; k++) rdat[k] = 32'hA0 + 32'(k);
    i_req_valid = 1; mem_req_ready = 1;
    #1;
    tests_run++;
    if ({mem_req_valid, i_req_ready} !== 2'b00) begin
      fails++;
      $display("FAIL req_latency0: v=%b rdy=%b required 00", mem_req_valid, i_req_ready);
    end
    nxt(); #1;
    tests_run++;
    if (mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL req_latency1: mem_req_valid=%b required 1", mem_req_valid);
    end
    model_grant(1'b1, 1'b0, who);
    serve_txn(who, 0, -1, 1'b1, 1'b0);
    i_req_valid = 0;
  endtask

  task automatic test_spurious_idle();
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1; mem_rlast = 1; mem_rdata = $urandom;
      #1;
      tests_run++;
      if (outs() !== 144'b0) begin
        fails++;
        $display("FAIL spurious_idle%0d: outputs=%h required 0", k, outs());
      end
      nxt();
    end
    mem_rvalid = 0; mem_rlast = 0;
  endtask

  task automatic test_data_write();
    logic who;
    d_req_addr = $urandom; d_req_len = 4'd1; d_req_write = 1;
    wdat[0] = 32'h1234; wdat[1] = 32'h5678;
    d_req_valid = 1;
    model_grant(1'b0, 1'b1, who);
    serve_txn(who, 0, 2, 1'b0, 1'b1);
    d_req_valid = 0;
  endtask

  task automatic test_addr_stall();
    logic who;
    fill_rand();
    d_req_addr = $urandom; d_req_len = 4'd2; d_req_write = 0;
    d_req_valid = 1;
    model_grant(1'b0, 1'b1, who);
    serve_txn(who, 5, -1, 1'b0, 1'b0);
    d_req_valid = 0;
  endtask

  task automatic test_starvation();
    logic who;
    i_req_addr = $urandom; i_req_len = LW'($urandom_range(0, 3));
    d_req_addr = $urandom; d_req_len = LW'($urandom_range(0, 3)); d_req_write = 0;
    i_req_valid = 1; d_req_valid = 1;
    for (int g = 0; g < 12; g++) begin
      fill_rand();
      model_grant(1'b1, 1'b1, who);
      serve_txn(who, -1, -1, 1'b1, 1'b0);
      if (who) begin
        d_req_addr = $urandom; d_req_len = LW'($urandom_range(0, 3));
        d_req_write = 1'($urandom_range(0, 1));
      end else begin
        i_req_addr = $urandom; i_req_len = LW'($urandom_range(0, 3));
      end
    end
    i_req_valid = 0; d_req_valid = 0;
  endtask

  task automatic test_reset_mid();
    logic          who;
    logic [DW-1:0] b0;
    i_req_addr = $urandom; i_req_len = 4'd3;
    i_req_valid = 1; mem_req_ready = 1;
    nxt();
    nxt();
    i_req_valid = 0; mem_req_ready = 0;
    b0 = $urandom;
    mem_rvalid = 1; mem_rdata = b0; mem_rlast = 0;
    #1;
    tests_run++;
    if ({i_rvalid, i_rdata, i_rlast} !== {1'b1, b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_beat1: got %b/%h/%b required 1/%h/0", i_rvalid, i_rdata, i_rlast, b0);
    end
    nxt();
    rst = 1; mem_rdata = $urandom;
    #1;
    tests_run++;
    if (outs() !== 144'b0) begin
      fails++;
      $display("FAIL rst_during_burst: outputs=%h required 0", outs());
    end
    nxt();
    rst = 0;
    streak = 0;
    #1;
    tests_run++;
    if (outs() !== 144'b0) begin
      fails++;
      $display("FAIL rst_after_burst: outputs=%h required 0", outs());
    end
    mem_rvalid = 0; mem_rlast = 0;
    fill_rand();
    i_req_addr = $urandom; i_req_len = 4'd1; i_req_valid = 1;
    model_grant(1'b1, 1'b0, who);
    serve_txn(who, 1, -1, 1'b0, 1'b0);
    i_req_valid = 0;
  endtask

  task automatic test_random();
    logic who;
    for (int r = 0; r < 25; r++) begin
      if (!i_req_valid && $urandom_range(0, 1) == 1) begin
        i_req_valid = 1; i_req_addr = $urandom; i_req_len = LW'($urandom_range(0, 3));
      end
      if (!d_req_valid && $urandom_range(0, 1) == 1) begin
        d_req_valid = 1; d_req_addr = $urandom; d_req_len = LW'($urandom_range(0, 3));
        d_req_write = 1'($urandom_range(0, 1));
      end
      if (!i_req_valid && !d_req_valid) begin
        d_req_valid = 1; d_req_addr = $urandom; d_req_len = LW'($urandom_range(0, 3));
        d_req_write = 1'($urandom_range(0, 1));
      end
      fill_rand();
      model_grant(i_req_valid, d_req_valid, who);
      serve_txn(who, -1, -1, 1'b1, 1'($urandom_range(0, 1)));
      if (who) d_req_valid = 0;
      else i_req_valid = 0;
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_spurious_idle();
    test_data_write();
    test_addr_stall();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
